// File: rtl/csi_pkg.sv
// Shared definitions for the CSI capture path: controller state codes,
// default window lengths and a parameter range helper.
package csi_pkg;

    // 3-bit state codes, also exported on state_out for debug
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_SEARCH  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    // Default window lengths, in valid samples
    localparam int DEF_SYNC_TIMEOUT = 320;
    localparam int DEF_CAPTURE_LEN  = 160;
    localparam int DEF_HOLDOFF_LEN  = 80;

    // Sample counter width and its saturation value
    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // A length must fit the 16-bit counter and be at least one sample
    function automatic logic len_ok(input int value);
        return (value >= 1) && (value <= 65535);
    endfunction

endpackage

// File: rtl/packet_capture_ctrl.sv
// Capture controller for the CSI buffer: waits for an arm request, follows
// the power trigger into a sync search, opens a fixed-length capture window
// on a sync hit, then holds off before it can be re-armed. All timing is in
// valid samples; cycles without signal_valid_in only honour arm/abort.
module packet_capture_ctrl
    import csi_pkg::*;
#(
    parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int CAPTURE_LEN  = DEF_CAPTURE_LEN,
    parameter int HOLDOFF_LEN  = DEF_HOLDOFF_LEN
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        signal_valid_in,
    input  logic        trigger_in,
    input  logic        sync_in,
    input  logic        arm_in,
    input  logic        abort_in,
    input  logic        cont_mode_in,
    output logic        search_en_out,
    output logic        capture_en_out,
    output logic        done_out,
    output logic        timeout_out,
    output logic [15:0] pkt_count_out,
    output logic [2:0]  state_out
);

    // Lengths outside the counter range cannot be honoured, so refuse to elaborate
    if (!len_ok(SYNC_TIMEOUT)) begin : g_bad_sync_timeout
        $error("SYNC_TIMEOUT must be within 1..65535");
    end
    if (!len_ok(CAPTURE_LEN)) begin : g_bad_capture_len
        $error("CAPTURE_LEN must be within 1..65535");
    end
    if (!len_ok(HOLDOFF_LEN)) begin : g_bad_holdoff_len
        $error("HOLDOFF_LEN must be within 1..65535");
    end

    // Counter values compared against: last search sample, last capture
    // sample, and the holdoff count that must already have elapsed
    localparam logic [CNT_W-1:0] SYNC_LAST    = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(CAPTURE_LEN - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_MIN  = CNT_W'(HOLDOFF_LEN);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             done_nxt;
    logic             timeout_nxt;

    assign state_out = state;

    // Next-state and counter rules; abort overrides everything, including arm
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        if (abort_in) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_in) begin
                        state_nxt = ST_ARMED;
                        count_nxt = '0;
                    end
                end
                ST_ARMED: begin
                    if (signal_valid_in && trigger_in) begin
                        state_nxt = ST_SEARCH;
                        count_nxt = '0;
                    end
                end
                ST_SEARCH: begin
                    if (signal_valid_in) begin
                        if (sync_in) begin
                            state_nxt = ST_CAPTURE;
                            count_nxt = '0;
                        end else if (!trigger_in || (count == SYNC_LAST)) begin
                            state_nxt   = ST_HOLDOFF;
                            count_nxt   = '0;
                            timeout_nxt = 1'b1;
                        end else begin
                            count_nxt = count + 16'd1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (signal_valid_in) begin
                        if (count == CAPTURE_LAST) begin
                            state_nxt = ST_HOLDOFF;
                            count_nxt = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            count_nxt = count + 16'd1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (signal_valid_in) begin
                        if ((count >= HOLDOFF_MIN) && !trigger_in) begin
                            state_nxt = cont_mode_in ? ST_ARMED : ST_IDLE;
                            count_nxt = '0;
                        end else if (count != CNT_MAX) begin
                            count_nxt = count + 16'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // State, counter and all outputs are registered; enables follow the next state
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            count          <= '0;
            pkt_count_out  <= '0;
            done_out       <= 1'b0;
            timeout_out    <= 1'b0;
            search_en_out  <= 1'b0;
            capture_en_out <= 1'b0;
        end else begin
            state          <= state_nxt;
            count          <= count_nxt;
            done_out       <= done_nxt;
            timeout_out    <= timeout_nxt;
            search_en_out  <= (state_nxt == ST_SEARCH);
            capture_en_out <= (state_nxt == ST_CAPTURE);
            if (done_nxt) begin
                pkt_count_out <= pkt_count_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_packet_capture_ctrl.sv
// Self-checking bench for packet_capture_ctrl. Expected outcomes come from
// sample-index arithmetic on the window lengths (where search, capture and
// holdoff must end) rather than from a cycle model of the controller.
module tb_packet_capture_ctrl;
    import csi_pkg::*;

    localparam int SYNC_TIMEOUT = 320;
    localparam int CAPTURE_LEN  = 160;
    localparam int HOLDOFF_LEN  = 80;
    localparam int BOUND        = 5000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        signal_valid_in = 1'b0;
    logic        trigger_in = 1'b0;
    logic        sync_in = 1'b0;
    logic        arm_in = 1'b0;
    logic        abort_in = 1'b0;
    logic        cont_mode_in = 1'b0;
    logic        search_en_out;
    logic        capture_en_out;
    logic        done_out;
    logic        timeout_out;
    logic [15:0] pkt_count_out;
    logic [2:0]  state_out;

    int total_checks = 0;
    int bad_checks   = 0;
    int exp_pkt      = 0;
    int mon_done     = 0;
    int mon_timeout  = 0;
    int mon_cap      = 0;

    packet_capture_ctrl #(
        .SYNC_TIMEOUT(SYNC_TIMEOUT),
        .CAPTURE_LEN (CAPTURE_LEN),
        .HOLDOFF_LEN (HOLDOFF_LEN)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .signal_valid_in(signal_valid_in),
        .trigger_in     (trigger_in),
        .sync_in        (sync_in),
        .arm_in         (arm_in),
        .abort_in       (abort_in),
        .cont_mode_in   (cont_mode_in),
        .search_en_out  (search_en_out),
        .capture_en_out (capture_en_out),
        .done_out       (done_out),
        .timeout_out    (timeout_out),
        .pkt_count_out  (pkt_count_out),
        .state_out      (state_out)
    );

    // Free-running clock
    always #5 clk_in = ~clk_in;

    // Pulse/enable cycle counters sampled mid-cycle
    always @(negedge clk_in) begin
        if (done_out)       mon_done    <= mon_done + 1;
        if (timeout_out)    mon_timeout <= mon_timeout + 1;
        if (capture_en_out) mon_cap     <= mon_cap + 1;
    end

    // Hard stop if the run ever stalls
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic rand_valid(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_arm();
        arm_in = 1'b1; abort_in = 1'b0; trigger_in = 1'b0; sync_in = 1'b0;
        signal_valid_in = 1'($urandom_range(0, 1));
        tick();
        arm_in = 1'b0;
    endtask

    task automatic do_enter_search();
        signal_valid_in = 1'b0; trigger_in = 1'b1; sync_in = 1'b0;
        tick();
        signal_valid_in = 1'b1;
        tick();
    endtask

    task automatic do_abort();
        abort_in = 1'b1; signal_valid_in = 1'b0;
        tick();
        abort_in = 1'b0;
    endtask

    // Drives search samples; returns the valid-sample index at which SEARCH was left
    task automatic run_search(input int sync_at, input int drop_at, input int pct, output int samples);
        int n = 0;
        int guard = 0;
        while (state_out == ST_SEARCH && guard < BOUND) begin
            guard++;
            signal_valid_in = rand_valid(pct);
            if (signal_valid_in) begin
                n++;
                sync_in    = (n == sync_at);
                trigger_in = !(drop_at != 0 && n >= drop_at);
            end else begin
                sync_in    = 1'($urandom_range(0, 1));
                trigger_in = 1'($urandom_range(0, 1));
            end
            tick();
        end
        sync_in = 1'b0; signal_valid_in = 1'b0;
        samples = n;
    endtask

    // Drives capture samples; counts qualified samples and done pulses
    task automatic run_capture(input int pct, input int abort_at, output int qual, output int dones);
        int guard = 0;
        qual = 0; dones = 0;
        while (state_out == ST_CAPTURE && guard < BOUND) begin
            guard++;
            signal_valid_in = rand_valid(pct);
            trigger_in = 1'($urandom_range(0, 1));
            sync_in    = 1'($urandom_range(0, 1));
            abort_in   = 1'b0;
            if (abort_at != 0 && qual == abort_at - 1) begin
                signal_valid_in = 1'b1;
                abort_in = 1'b1;
            end
            if (signal_valid_in && capture_en_out) qual++;
            tick();
            if (done_out) dones++;
        end
        abort_in = 1'b0; signal_valid_in = 1'b0; sync_in = 1'b0;
    endtask

    // Drives holdoff samples with trigger high for the first trig_hold samples
    task automatic run_holdoff(input int trig_hold, input int pct, output int samples);
        int n = 0;
        int guard = 0;
        while (state_out == ST_HOLDOFF && guard < BOUND) begin
            guard++;
            signal_valid_in = rand_valid(pct);
            if (signal_valid_in) begin
                n++;
                trigger_in = (n <= trig_hold);
            end else begin
                trigger_in = 1'($urandom_range(0, 1));
            end
            tick();
        end
        signal_valid_in = 1'b0; trigger_in = 1'b0;
        samples = n;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; arm_in = 1'b1; abort_in = 1'b1;
        signal_valid_in = 1'b1; trigger_in = 1'b1; sync_in = 1'b1;
        tick(); tick();
        total_checks++;
        if (state_out !== ST_IDLE) begin bad_checks++; $display("[TB] FAIL reset_state: got %0d want %0d", state_out, ST_IDLE); end
        total_checks++;
        if ({search_en_out, capture_en_out, done_out, timeout_out} !== 4'b0000) begin
            bad_checks++; $display("[TB] FAIL reset_flags: got %b want 0000", {search_en_out, capture_en_out, done_out, timeout_out});
        end
        total_checks++;
        if (pkt_count_out !== 16'd0) begin bad_checks++; $display("[TB] FAIL reset_pkt: got %0d want 0", pkt_count_out); end
        rst_in = 1'b0; arm_in = 1'b0; abort_in = 1'b0;
        signal_valid_in = 1'b0; trigger_in = 1'b0; sync_in = 1'b0;
        tick();
        exp_pkt = 0;
    endtask

    task automatic test_capture_basic();
        int s, q, d, cap0, dn0, to0;
        do_arm();
        total_checks++;
        if (state_out !== ST_ARMED) begin bad_checks++; $display("[TB] FAIL arm_state: got %0d want %0d", state_out, ST_ARMED); end
        do_enter_search();
        total_checks++;
        if (!(state_out === ST_SEARCH && search_en_out === 1'b1)) begin
            bad_checks++; $display("[TB] FAIL search_entry: got state %0d en %b want %0d en 1", state_out, search_en_out, ST_SEARCH);
        end
        cap0 = mon_cap; dn0 = mon_done; to0 = mon_timeout;
        run_search(5, 0, 100, s);
        total_checks++;
        if (!(s == 5 && state_out === ST_CAPTURE && capture_en_out === 1'b1 && search_en_out === 1'b0)) begin
            bad_checks++; $display("[TB] FAIL sync_hit: got sample %0d state %0d cap %b want 5 %0d 1", s, state_out, capture_en_out, ST_CAPTURE);
        end
        run_capture(100, 0, q, d);
        exp_pkt = (exp_pkt + 1) % 65536;
        total_checks++;
        if (q != CAPTURE_LEN || d != 1) begin bad_checks++; $display("[TB] FAIL basic_window: got %0d samples %0d done want %0d 1", q, d, CAPTURE_LEN); end
        total_checks++;
        if (pkt_count_out !== 16'(exp_pkt)) begin bad_checks++; $display("[TB] FAIL basic_pkt: got %0d want %0d", pkt_count_out, exp_pkt); end
        signal_valid_in = 1'b0;
        tick();
        total_checks++;
        if (!(done_out === 1'b0 && state_out === ST_HOLDOFF)) begin
            bad_checks++; $display("[TB] FAIL done_pulse: got done %b state %0d want 0 %0d", done_out, state_out, ST_HOLDOFF);
        end
        total_checks++;
        if (mon_cap - cap0 != CAPTURE_LEN || mon_done - dn0 != 1 || mon_timeout - to0 != 0) begin
            bad_checks++; $display("[TB] FAIL basic_cycles: got cap %0d done %0d to %0d want %0d 1 0", mon_cap - cap0, mon_done - dn0, mon_timeout - to0, CAPTURE_LEN);
        end
        run_holdoff(0, 100, s);
        total_checks++;
        if (s != HOLDOFF_LEN + 1 || state_out !== ST_IDLE) begin
            bad_checks++; $display("[TB] FAIL basic_holdoff: got %0d state %0d want %0d %0d", s, state_out, HOLDOFF_LEN + 1, ST_IDLE);
        end
    endtask

    task automatic test_search_timeout();
        int s, th, cap0, to0;
        do_arm(); do_enter_search();
        cap0 = mon_cap; to0 = mon_timeout;
        run_search(0, 0, 50, s);
        total_checks++;
        if (!(s == SYNC_TIMEOUT && timeout_out === 1'b1 && state_out === ST_HOLDOFF)) begin
            bad_checks++; $display("[TB] FAIL search_timeout: got %0d to %b state %0d want %0d 1 %0d", s, timeout_out, state_out, SYNC_TIMEOUT, ST_HOLDOFF);
        end
        tick();
        total_checks++;
        if (mon_timeout - to0 != 1 || mon_cap != cap0 || pkt_count_out !== 16'(exp_pkt)) begin
            bad_checks++; $display("[TB] FAIL timeout_side: got to %0d cap %0d pkt %0d want 1 0 %0d", mon_timeout - to0, mon_cap - cap0, pkt_count_out, exp_pkt);
        end
        th = int'($urandom_range(0, 120));
        run_holdoff(th, 50, s);
        total_checks++;
        if (s != max_int(HOLDOFF_LEN + 1, th + 1) || state_out !== ST_IDLE) begin
            bad_checks++; $display("[TB] FAIL timeout_holdoff: got %0d state %0d want %0d %0d", s, state_out, max_int(HOLDOFF_LEN + 1, th + 1), ST_IDLE);
        end
    endtask

    task automatic test_trigger_loss();
        int s;
        do_arm(); do_enter_search();
        run_search(0, 10, 70, s);
        total_checks++;
        if (!(s == 10 && timeout_out === 1'b1 && state_out === ST_HOLDOFF)) begin
            bad_checks++; $display("[TB] FAIL trigger_loss: got %0d to %b state %0d want 10 1 %0d", s, timeout_out, state_out, ST_HOLDOFF);
        end
        run_holdoff(0, 70, s);
        total_checks++;
        if (s != HOLDOFF_LEN + 1 || state_out !== ST_IDLE) begin
            bad_checks++; $display("[TB] FAIL loss_holdoff: got %0d state %0d want %0d %0d", s, state_out, HOLDOFF_LEN + 1, ST_IDLE);
        end
    endtask

    task automatic test_cont_mode();
        int s, drop, th;
        cont_mode_in = 1'b1;
        drop = int'($urandom_range(1, 30));
        do_arm(); do_enter_search();
        run_search(0, drop, 100, s);
        total_checks++;
        if (s != drop || state_out !== ST_HOLDOFF) begin bad_checks++; $display("[TB] FAIL cont_drop: got %0d state %0d want %0d %0d", s, state_out, drop, ST_HOLDOFF); end
        th = HOLDOFF_LEN + int'($urandom_range(1, 40));
        run_holdoff(th, 80, s);
        total_checks++;
        if (s != th + 1 || state_out !== ST_ARMED) begin
            bad_checks++; $display("[TB] FAIL cont_rearm: got %0d state %0d want %0d %0d", s, state_out, th + 1, ST_ARMED);
        end
        do_abort();
        total_checks++;
        if (state_out !== ST_IDLE) begin bad_checks++; $display("[TB] FAIL abort_armed: got %0d want %0d", state_out, ST_IDLE); end
        cont_mode_in = 1'b0;
    endtask

    task automatic test_abort_capture();
        int s, q, d, dn0, to0;
        do_arm(); do_enter_search();
        run_search(int'($urandom_range(1, 50)), 0, 100, s);
        dn0 = mon_done; to0 = mon_timeout;
        run_capture(50, 50, q, d);
        total_checks++;
        if (!(q == 50 && d == 0 && state_out === ST_IDLE && capture_en_out === 1'b0 && search_en_out === 1'b0)) begin
            bad_checks++; $display("[TB] FAIL abort_capture: got %0d samples %0d done state %0d cap %b want 50 0 %0d 0", q, d, state_out, capture_en_out, ST_IDLE);
        end
        tick();
        total_checks++;
        if (mon_done != dn0 || mon_timeout != to0 || pkt_count_out !== 16'(exp_pkt)) begin
            bad_checks++; $display("[TB] FAIL abort_side: got done %0d to %0d pkt %0d want 0 0 %0d", mon_done - dn0, mon_timeout - to0, pkt_count_out, exp_pkt);
        end
        do_arm(); do_enter_search();
        run_search(int'($urandom_range(1, 50)), 0, 50, s);
        run_capture(50, 0, q, d);
        exp_pkt = (exp_pkt + 1) % 65536;
        total_checks++;
        if (q != CAPTURE_LEN || d != 1 || pkt_count_out !== 16'(exp_pkt)) begin
            bad_checks++; $display("[TB] FAIL sparse_window: got %0d samples %0d done pkt %0d want %0d 1 %0d", q, d, pkt_count_out, CAPTURE_LEN, exp_pkt);
        end
        do_abort();
    endtask

    task automatic test_arm_rules();
        arm_in = 1'b1; abort_in = 1'b1;
        tick();
        arm_in = 1'b0; abort_in = 1'b0;
        total_checks++;
        if (state_out !== ST_IDLE) begin bad_checks++; $display("[TB] FAIL abort_beats_arm: got %0d want %0d", state_out, ST_IDLE); end
        do_arm(); do_enter_search();
        arm_in = 1'b1; signal_valid_in = 1'b0; sync_in = 1'b1; trigger_in = 1'b0;
        repeat (4) tick();
        arm_in = 1'b0; sync_in = 1'b0; trigger_in = 1'b1; signal_valid_in = 1'b1;
        repeat (3) tick();
        total_checks++;
        if (!(state_out === ST_SEARCH && search_en_out === 1'b1 && timeout_out === 1'b0)) begin
            bad_checks++; $display("[TB] FAIL search_frozen: got state %0d en %b to %b want %0d 1 0", state_out, search_en_out, timeout_out, ST_SEARCH);
        end
        do_abort();
        total_checks++;
        if (!(state_out === ST_IDLE && search_en_out === 1'b0 && timeout_out === 1'b0)) begin
            bad_checks++; $display("[TB] FAIL abort_search: got state %0d en %b to %b want %0d 0 0", state_out, search_en_out, timeout_out, ST_IDLE);
        end
    endtask

    task automatic test_random_captures();
        int s, q, d, th, sync_at, drop_at, pct, lim, exp_s;
        bit captured;
        for (int iter = 0; iter < 6; iter++) begin
            cont_mode_in = 1'($urandom_range(0, 1));
            sync_at = int'($urandom_range(1, 400));
            drop_at = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 400));
            pct = int'($urandom_range(30, 100));
            lim = SYNC_TIMEOUT;
            if (drop_at != 0 && drop_at < lim) lim = drop_at;
            captured = (sync_at <= lim);
            exp_s = captured ? sync_at : lim;
            do_arm();
            total_checks++;
            if (state_out !== ST_ARMED) begin bad_checks++; $display("[TB] FAIL rand_arm: got %0d want %0d", state_out, ST_ARMED); end
            do_enter_search();
            run_search(sync_at, drop_at, pct, s);
            total_checks++;
            if (s != exp_s || state_out !== (captured ? ST_CAPTURE : ST_HOLDOFF)) begin
                bad_checks++; $display("[TB] FAIL rand_search: got %0d state %0d want %0d captured %0d", s, state_out, exp_s, captured);
            end
            if (captured) begin
                run_capture(pct, 0, q, d);
                exp_pkt = (exp_pkt + 1) % 65536;
                total_checks++;
                if (q != CAPTURE_LEN || d != 1) begin bad_checks++; $display("[TB] FAIL rand_window: got %0d samples %0d done want %0d 1", q, d, CAPTURE_LEN); end
            end
            total_checks++;
            if (pkt_count_out !== 16'(exp_pkt)) begin bad_checks++; $display("[TB] FAIL rand_pkt: got %0d want %0d", pkt_count_out, exp_pkt); end
            th = int'($urandom_range(0, 120));
            run_holdoff(th, pct, s);
            total_checks++;
            if (s != max_int(HOLDOFF_LEN + 1, th + 1) || state_out !== (cont_mode_in ? ST_ARMED : ST_IDLE)) begin
                bad_checks++; $display("[TB] FAIL rand_holdoff: got %0d state %0d want %0d cont %b", s, state_out, max_int(HOLDOFF_LEN + 1, th + 1), cont_mode_in);
            end
        end
        cont_mode_in = 1'b0;
        do_abort();
    endtask

    task automatic test_reset_mid_capture();
        int s, dn0;
        do_arm(); do_enter_search();
        run_search(3, 0, 100, s);
        dn0 = mon_done;
        signal_valid_in = 1'b1;
        repeat (20) tick();
        rst_in = 1'b1; abort_in = 1'b1; arm_in = 1'b1;
        tick();
        rst_in = 1'b0; abort_in = 1'b0; arm_in = 1'b0; signal_valid_in = 1'b0;
        exp_pkt = 0;
        total_checks++;
        if (!(state_out === ST_IDLE && capture_en_out === 1'b0 && pkt_count_out === 16'd0)) begin
            bad_checks++; $display("[TB] FAIL reset_capture: got state %0d cap %b pkt %0d want %0d 0 0", state_out, capture_en_out, pkt_count_out, ST_IDLE);
        end
        tick();
        total_checks++;
        if (mon_done != dn0) begin bad_checks++; $display("[TB] FAIL reset_no_done: got %0d want 0", mon_done - dn0); end
    endtask

    task automatic test_wrap();
        int s, q, d;
        force dut.pkt_count_out = 16'hFFFF;
        tick();
        release dut.pkt_count_out;
        exp_pkt = 65535;
        do_arm(); do_enter_search();
        run_search(int'($urandom_range(1, 20)), 0, 100, s);
        run_capture(100, 0, q, d);
        exp_pkt = (exp_pkt + 1) % 65536;
        total_checks++;
        if (d != 1 || pkt_count_out !== 16'(exp_pkt)) begin
            bad_checks++; $display("[TB] FAIL pkt_wrap: got %0d done pkt %0d want 1 %0d", d, pkt_count_out, exp_pkt);
        end
    endtask

    // Scenario sequence
    initial begin
        tick();
        test_reset();
        test_capture_basic();
        test_search_timeout();
        test_trigger_loss();
        test_cont_mode();
        test_abort_capture();
        test_arm_rules();
        test_random_captures();
        test_reset_mid_capture();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/packet_capture_ctrl.md
PACKET_CAPTURE_CTRL -- requirements
Module: packet_capture_ctrl

Interface
REQ-001 SHALL have parameter SYNC_TIMEOUT, default 320: max valid samples in SEARCH before giving up.
REQ-002 SHALL have parameter CAPTURE_LEN, default 160: valid samples per capture window.
REQ-003 SHALL have parameter HOLDOFF_LEN, default 80: min valid samples in HOLDOFF before re-arming.
REQ-004 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port signal_valid_in  input  1  sample strobe; all counters advance only on it.
REQ-007 SHALL have port trigger_in  input  1  level from the power trigger.
REQ-008 SHALL have port sync_in  input  1  sync-detector hit, sampled only with signal_valid_in.
REQ-009 SHALL have port arm_in  input  1  one-cycle arm request.
REQ-010 SHALL have port abort_in  input  1  one-cycle abort request.
REQ-011 SHALL have port cont_mode_in  input  1  1 = auto re-arm after HOLDOFF.
REQ-012 SHALL have port search_en_out  output  1  enables the sync detector.
REQ-013 SHALL have port capture_en_out  output  1  qualifies samples written to the CSI buffer.
REQ-014 SHALL have port done_out  output  1  one-cycle pulse at capture completion.
REQ-015 SHALL have port timeout_out  output  1  one-cycle pulse on search timeout or trigger loss.
REQ-016 SHALL have port pkt_count_out  output  16  completed captures, wraps at 65535 -> 0.
REQ-017 SHALL have port state_out  output  3  encoded current state for debug.

Function
REQ-018 SHALL implement states IDLE, ARMED, SEARCH, CAPTURE, HOLDOFF; all outputs are registered.
REQ-019 IDLE: arm_in -> ARMED next cycle; no other exit except reset.
REQ-020 ARMED: signal_valid_in & trigger_in -> SEARCH; sample counter cleared.
REQ-021 SEARCH: search_en_out=1; each valid sample increments counter.
REQ-022 SEARCH: valid & sync_in -> CAPTURE, counter cleared, regardless of counter or trigger_in.
REQ-023 SEARCH: valid & !sync_in & (trigger_in==0 or counter==SYNC_TIMEOUT-1) -> HOLDOFF, timeout_out pulses 1 cycle.
REQ-024 CAPTURE: capture_en_out=1 from the cycle after the sync sample; high for exactly CAPTURE_LEN valid samples; trigger_in ignored.
REQ-025 CAPTURE: on valid sample CAPTURE_LEN, done_out pulses 1 cycle, pkt_count_out increments, counter clears -> HOLDOFF.
REQ-026 HOLDOFF: exit when counter >= HOLDOFF_LEN and trigger_in==0 on a valid sample; cont_mode_in=1 -> ARMED, else IDLE.
REQ-027 abort_in in any state SHALL force IDLE next cycle: search_en_out, capture_en_out deasserted, counter cleared, no done_out/timeout_out; pkt_count_out kept.
REQ-028 abort_in and arm_in in the same cycle: abort wins.
REQ-029 arm_in outside IDLE SHALL be ignored.
REQ-030 Counter SHALL be 16 bits; parameters SHALL be elaboration-checked 1..65535.
REQ-031 signal_valid_in low SHALL freeze state and counters; non-valid cycles never cause transitions except arm_in/abort_in.

Reset
REQ-032 rst_in SHALL set state IDLE, counter 0, pkt_count_out 0, all 1-bit outputs 0, state_out = IDLE code.
REQ-033 rst_in SHALL take priority over abort_in and arm_in; reset mid-CAPTURE drops the capture without a done_out pulse.

Structure
REQ-034 State enum and its 3-bit encoding SHALL live in a shared package csi_pkg alongside default length constants.
REQ-035 Single module; no sub-module required, counter inline.

Verification
REQ-036 Reset, arm_in, trigger_in=1, sync_in at 5th search sample, all-valid -> capture_en_out high exactly 160 cycles, done_out once, pkt_count_out=1.
REQ-037 Armed, trigger_in held 1, no sync_in -> timeout_out pulse after 320 valid samples, capture_en_out never high, pkt_count_out unchanged.
REQ-038 trigger_in drops at search sample 10 -> timeout_out at that sample; HOLDOFF exits after 80 samples to IDLE (cont_mode_in=0).
REQ-039 cont_mode_in=1, trigger_in held high through HOLDOFF past 80 samples -> stays HOLDOFF until trigger_in=0, then ARMED.
REQ-040 abort_in at capture sample 50 -> IDLE next cycle, no done_out, pkt_count_out unchanged; signal_valid_in toggled 50% -> window still 160 valid samples.
REQ-041 pkt_count_out preloaded via 65535 captures (or forced) -> next done_out wraps to 0.
